// File: rtl/mem_block_copier.sv
// Word-by-word memory block copier: alternating READ/WRITE cycles per word, one-cycle Done pulse.
// Define MEM_BLOCK_COPIER_CHECKSUM_EN to accumulate a running sum of copied words on Checksum.
//
// state | meaning
// IDLE  | waiting for Start; Address/WriteData hold last driven values
// READ  | MemRead=1, Address=src pointer, ReadData captured into buffer
// WRITE | MemWrite=1, Address=dst pointer, WriteData=buffer; pointers advance
// DONE  | Done=1 for one cycle, then back to IDLE
module mem_block_copier #(
    parameter int ADDR_W = 9
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic [ADDR_W-1:0] SrcAddr,
    input  logic [ADDR_W-1:0] DstAddr,
    input  logic [ADDR_W:0]   Count,
    output logic              Busy,
    output logic              Done,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [31:0]       Address,
    output logic [31:0]       WriteData,
    input  logic [31:0]       ReadData,
    output logic [31:0]       Checksum
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] src_ptr, dst_ptr;
    logic [ADDR_W-1:0] addr_hold, addr_cur;
    logic [ADDR_W:0]   remaining;
    logic [31:0]       buffer;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        Busy      = 1'b0;
        Done      = 1'b0;
        addr_cur  = addr_hold;
        case (state)
            IDLE: begin
                if (Start) state_nxt = (Count != '0) ? READ : DONE;
            end
            READ: begin
                MemRead   = 1'b1;
                Busy      = 1'b1;
                addr_cur  = src_ptr;
                state_nxt = WRITE;
            end
            WRITE: begin
                MemWrite  = 1'b1;
                Busy      = 1'b1;
                addr_cur  = dst_ptr;
                state_nxt = (remaining > (ADDR_W+1)'(1)) ? READ : DONE;
            end
            DONE: begin
                Done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign Address   = {{(32-ADDR_W){1'b0}}, addr_cur};
    // buffer only changes in READ, so it doubles as the held WriteData value
    assign WriteData = buffer;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            src_ptr   <= '0;
            dst_ptr   <= '0;
            remaining <= '0;
            buffer    <= '0;
            addr_hold <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        src_ptr   <= SrcAddr;
                        dst_ptr   <= DstAddr;
                        remaining <= Count;
                    end
                end
                READ: begin
                    buffer    <= ReadData;
                    addr_hold <= src_ptr;
                end
                WRITE: begin
                    src_ptr   <= src_ptr + ADDR_W'(1);
                    dst_ptr   <= dst_ptr + ADDR_W'(1);
                    remaining <= remaining - (ADDR_W+1)'(1);
                    addr_hold <= dst_ptr;
                end
                default: ;
            endcase
        end
    end

`ifdef MEM_BLOCK_COPIER_CHECKSUM_EN
    logic [31:0] checksum_q;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)                      checksum_q <= '0;
        else if (state == IDLE && Start) checksum_q <= '0;
        else if (state == WRITE)      checksum_q <= checksum_q + buffer;
    end

    assign Checksum = checksum_q;
`else
    assign Checksum = '0;
`endif

endmodule
